ir_queue: RTL and testbench

Parametrised instruction queue that sits between instruction fetch and the decode/control unit. It replaces the single-entry instruction register with a DEPTH-entry FIFO of INS_W-bit instruction words, so fetch can run ahead of decode. Both sides use a valid/ready handshake. An optional flush discards all buffered instructions on a branch or jump.

---
 rtl/ir_pkg.sv | 7 +
 rtl/ir_ptr.sv | 28 ++
 rtl/ir_queue.sv | 94 +++++++++
 tb/tb_ir_queue.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// Shared instruction-queue types and default sizing used by fetch, queue and decode.
package ir_pkg;
  localparam int unsigned INS_W_DEF = 16;
  localparam int unsigned DEPTH_DEF = 4;

  typedef logic [INS_W_DEF-1:0] ins_t;
endpackage

// File: rtl/ir_ptr.sv
// Wrapping log2(DEPTH)-bit queue pointer; clr has priority over inc.
module ir_ptr
  import ir_pkg::*;
#(
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] r_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (clr) begin
      r_ptr <= '0;
    end else if (inc) begin
      r_ptr <= r_ptr + PTR_W'(1);
    end
  end

  assign ptr = r_ptr;

endmodule

// File: rtl/ir_queue.sv
// DEPTH-entry instruction FIFO between fetch and decode with valid/ready on both sides.
// Optional flush port enabled by defining IR_FLUSH_EN.
module ir_queue
  import ir_pkg::*;
#(
  parameter int unsigned INS_W = INS_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [INS_W-1:0] ins,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [INS_W-1:0] ir_out,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef IR_FLUSH_EN
  input  logic             flush,
`endif
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("ir_queue: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  logic [INS_W-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_wr_ptr;
  logic [PTR_W-1:0] w_rd_ptr;
  logic             w_flush;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_push;
  logic             w_pop;

`ifdef IR_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // Full refuses a push even when a pop happens in the same cycle (no fall-through).
  assign w_in_ready  = (r_count != CNT_W'(DEPTH));
  assign w_out_valid = (r_count != '0);
  assign w_push      = in_valid && w_in_ready && !w_flush;
  assign w_pop       = w_out_valid && out_ready && !w_flush;

  ir_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (w_push),
    .clr (w_flush),
    .ptr (w_wr_ptr)
  );

  ir_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (w_pop),
    .clr (w_flush),
    .ptr (w_rd_ptr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_flush) begin
      r_count <= '0;
    end else if (w_push && !w_pop) begin
      r_count <= r_count + CNT_W'(1);
    end else if (w_pop && !w_push) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  // Storage is intentionally not reset; occupancy is tracked by count and pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[w_wr_ptr] <= ins;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign ir_out    = w_out_valid ? r_mem[w_rd_ptr] : '0;
  assign count     = r_count;

endmodule

// File: tb/tb_ir_queue.sv
// Self-checking bench for ir_queue: directed vector table, hand sequences and random traffic vs a queue model.
module tb_ir_queue;

  localparam int unsigned INS_W = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;

  logic             clk;
  logic             rst;
  logic [INS_W-1:0] ins;
  logic             in_valid;
  logic             in_ready;
  logic [INS_W-1:0] ir_out;
  logic             out_valid;
  logic             out_ready;
  logic             flush;
  logic [CNT_W-1:0] count;

  int n_checks;
  int n_errors;

  logic [INS_W-1:0] mq [$];

  ir_queue #(.INS_W(INS_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .ins       (ins),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ir_out    (ir_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef IR_FLUSH_EN
    .flush     (flush),
`endif
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic             iv;
    logic [INS_W-1:0] d;
    logic             ordy;
    logic [CNT_W-1:0] e_cnt;
    logic             e_ov;
    logic [INS_W-1:0] e_ir;
    logic             e_rdy;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the queue model.
  task automatic chk_model(input string tag);
    int sz;
    sz = mq.size();
    chk({tag, ".count"}, 32'(count), 32'(sz));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(sz != DEPTH));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(sz != 0));
    chk({tag, ".ir_out"}, 32'(ir_out), (sz != 0) ? 32'(mq[0]) : 32'h0);
  endtask

  // Called at a falling edge: drive inputs, advance the model, wait one clock, check.
  task automatic cycle(input logic iv, input logic [INS_W-1:0] d, input logic ordy,
                       input logic fl, input string tag);
    bit do_push;
    bit do_pop;
    in_valid  = iv;
    ins       = d;
    out_ready = ordy;
    flush     = fl;
    do_push = iv && (mq.size() != DEPTH) && !fl;
    do_pop  = ordy && (mq.size() != 0) && !fl;
    if (fl) mq.delete();
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back(d);
    @(posedge clk);
    @(negedge clk);
    chk_model(tag);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    ins       = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;

    vecs[0]  = '{1'b1, 16'h1111, 1'b0, 3'd1, 1'b1, 16'h1111, 1'b1};
    vecs[1]  = '{1'b1, 16'h2222, 1'b0, 3'd2, 1'b1, 16'h1111, 1'b1};
    vecs[2]  = '{1'b1, 16'h3333, 1'b0, 3'd3, 1'b1, 16'h1111, 1'b1};
    vecs[3]  = '{1'b1, 16'h4444, 1'b0, 3'd4, 1'b1, 16'h1111, 1'b0};
    vecs[4]  = '{1'b1, 16'h5555, 1'b0, 3'd4, 1'b1, 16'h1111, 1'b0};
    vecs[5]  = '{1'b1, 16'h6666, 1'b1, 3'd3, 1'b1, 16'h2222, 1'b1};
    vecs[6]  = '{1'b1, 16'h6666, 1'b0, 3'd4, 1'b1, 16'h2222, 1'b0};
    vecs[7]  = '{1'b0, 16'h0000, 1'b1, 3'd3, 1'b1, 16'h3333, 1'b1};
    vecs[8]  = '{1'b0, 16'h0000, 1'b1, 3'd2, 1'b1, 16'h4444, 1'b1};
    vecs[9]  = '{1'b0, 16'h0000, 1'b1, 3'd1, 1'b1, 16'h6666, 1'b1};
    vecs[10] = '{1'b0, 16'h0000, 1'b1, 3'd0, 1'b0, 16'h0000, 1'b1};
    vecs[11] = '{1'b0, 16'h0000, 1'b1, 3'd0, 1'b0, 16'h0000, 1'b1};
    vecs[12] = '{1'b1, 16'hABCD, 1'b0, 3'd1, 1'b1, 16'hABCD, 1'b1};
    vecs[13] = '{1'b1, 16'hBEEF, 1'b1, 3'd1, 1'b1, 16'hBEEF, 1'b1};
    vecs[14] = '{1'b0, 16'h0000, 1'b1, 3'd0, 1'b0, 16'h0000, 1'b1};

    // Reset state without any clock edge.
    #2;
    chk("rst0.count", 32'(count), 32'd0);
    chk("rst0.out_valid", 32'(out_valid), 32'd0);
    chk("rst0.ir_out", 32'(ir_out), 32'h0);
    chk("rst0.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Directed vector table: fill, refused push, full edge, drain, empty latency.
    for (int i = 0; i < 15; i++) begin
      cycle(vecs[i].iv, vecs[i].d, vecs[i].ordy, 1'b0, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tab_count", i), 32'(count), 32'(vecs[i].e_cnt));
      chk($sformatf("vec%0d.tab_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("vec%0d.tab_ir_out", i), 32'(ir_out), 32'(vecs[i].e_ir));
      chk($sformatf("vec%0d.tab_in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
    end

    // Concurrent push/pop at count 2 across pointer wrap.
    cycle(1'b1, 16'hC000, 1'b0, 1'b0, "conc_pre0");
    cycle(1'b1, 16'hC001, 1'b0, 1'b0, "conc_pre1");
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 16'hC002 + 16'(i), 1'b1, 1'b0, $sformatf("conc%0d", i));
      chk($sformatf("conc%0d.count2", i), 32'(count), 32'd2);
    end

    // Asynchronous reset mid-stream with count 3.
    cycle(1'b1, 16'hD000, 1'b0, 1'b0, "prerst");
    chk("prerst.count3", 32'(count), 32'd3);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("rst1.count", 32'(count), 32'd0);
    chk("rst1.out_valid", 32'(out_valid), 32'd0);
    chk("rst1.ir_out", 32'(ir_out), 32'h0);
    chk("rst1.in_ready", 32'(in_ready), 32'd1);
    mq.delete();
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 16'h0F0F, 1'b0, 1'b0, "postrst");

`ifdef IR_FLUSH_EN
    // Flush with a concurrent push at count 3.
    cycle(1'b1, 16'hE001, 1'b0, 1'b0, "fl_pre0");
    cycle(1'b1, 16'hE002, 1'b0, 1'b0, "fl_pre1");
    cycle(1'b1, 16'hBEEF, 1'b1, 1'b1, "flush");
    chk("flush.count0", 32'(count), 32'd0);
    chk("flush.out_valid0", 32'(out_valid), 32'd0);
    cycle(1'b1, 16'h1234, 1'b0, 1'b0, "fl_post");
    chk("fl_post.head", 32'(ir_out), 32'h1234);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic fl;
      fl = 1'b0;
`ifdef IR_FLUSH_EN
      fl = ($urandom_range(0, 19) == 0);
`endif
      cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), fl,
            $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
